// File: rtl/ysyx_24080014_fetch_ctrl_if.sv
// Fetch-side bundle: IFU read channel (ar/r) plus the instruction hand-off to decode.
// master = fetch sequencer, slave = memory port / decode stage.
interface ysyx_24080014_fetch_ctrl_if;
   logic        mem_arvalid;
   logic [31:0] mem_araddr;
   logic        mem_arready;
   logic        mem_rvalid;
   logic [31:0] mem_rdata;
   logic [1:0]  mem_rresp;
   logic        mem_rready;
   logic        inst_valid;
   logic [31:0] inst;
   logic [31:0] inst_pc;
   logic        inst_ready;

   modport master (
      output mem_arvalid, mem_araddr, mem_rready, inst_valid, inst, inst_pc,
      input  mem_arready, mem_rvalid, mem_rdata, mem_rresp, inst_ready
   );

   modport slave (
      input  mem_arvalid, mem_araddr, mem_rready, inst_valid, inst, inst_pc,
      output mem_arready, mem_rvalid, mem_rdata, mem_rresp, inst_ready
   );
endinterface

// File: rtl/ysyx_24080014_fetch_ctrl.sv
// Fetch sequencer owning the PC; one outstanding read, redirects discard in-flight data.
// Latency: 2 cycles min from request to inst_valid; optional watchdog under FETCH_TIMEOUT_EN.
// Backpressure: request held until mem_arready, instruction held until inst_ready.
module ysyx_24080014_fetch_ctrl #(
   parameter logic [31:0] RESET_PC       = 32'h8000_0000,
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic                              clk,
   input  logic                              rst,
   ysyx_24080014_fetch_ctrl_if.master        bus,
   input  logic                              redirect_valid_i,
   input  logic [31:0]                       redirect_pc_i,
   output logic [31:0]                       pc_o,
   output logic                              fetch_err_o
);

   typedef enum logic [1:0] {S_REQ, S_WAIT, S_HOLD, S_ERR} state_e;

   state_e      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] araddr_q, araddr_d;
   logic [31:0] inst_q, inst_d;
   logic [31:0] inst_pc_q, inst_pc_d;
   logic        inst_valid_q, inst_valid_d;
   logic        discard_q, discard_d;
   logic        err_q, err_d;
   logic        ar_hs;
   logic        tmo_hit;
   logic [31:0] pc_inc;

   assign ar_hs  = bus.mem_arvalid & bus.mem_arready;
   assign pc_inc = pc_q + 32'd4;

`ifdef FETCH_TIMEOUT_EN
   localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);
   logic [15:0] tmo_q, tmo_d;

   assign tmo_hit = ((state_q == S_REQ) || (state_q == S_WAIT)) && (tmo_q == TMO_LAST);

   // Leaving HOLD/ERR always passes through a non-REQ/WAIT cycle, so zeroing there clears on re-entry.
   always_comb begin
      tmo_d = 16'd0;
      if (!redirect_valid_i && ((state_q == S_REQ) || (state_q == S_WAIT)))
         tmo_d = tmo_q + 16'd1;
   end

   always_ff @(posedge clk) begin
      if (rst) tmo_q <= 16'd0;
      else     tmo_q <= tmo_d;
   end
`else
   logic [31:0] unused_timeout;
   assign unused_timeout = TIMEOUT_CYCLES;
   assign tmo_hit        = 1'b0;
`endif

   always_comb begin
      state_d      = state_q;
      pc_d         = pc_q;
      araddr_d     = araddr_q;
      inst_d       = inst_q;
      inst_pc_d    = inst_pc_q;
      inst_valid_d = inst_valid_q;
      discard_d    = discard_q;
      err_d        = err_q;

      case (state_q)
         S_REQ: begin
            if (ar_hs) state_d = S_WAIT;
         end
         S_WAIT: begin
            if (bus.mem_rvalid) begin
               if (discard_q) begin
                  discard_d = 1'b0;
                  araddr_d  = pc_q;
                  state_d   = S_REQ;
               end else if (bus.mem_rresp != 2'b00) begin
                  err_d   = 1'b1;
                  state_d = S_ERR;
               end else begin
                  inst_d       = bus.mem_rdata;
                  inst_pc_d    = araddr_q;
                  inst_valid_d = 1'b1;
                  state_d      = S_HOLD;
               end
            end
         end
         S_HOLD: begin
            if (bus.inst_ready) begin
               inst_valid_d = 1'b0;
               pc_d         = pc_inc;
               araddr_d     = pc_inc;
               state_d      = S_REQ;
            end
         end
         default: begin
            inst_valid_d = 1'b0;
         end
      endcase

      if (tmo_hit && ((state_d == S_REQ) || (state_d == S_WAIT))) begin
         err_d     = 1'b1;
         discard_d = 1'b0;
         state_d   = S_ERR;
      end

      // Redirect wins over everything except reset; a visible request is never retracted.
      if (redirect_valid_i) begin
         pc_d         = redirect_pc_i;
         inst_d       = inst_q;
         inst_pc_d    = inst_pc_q;
         inst_valid_d = 1'b0;
         err_d        = err_q;
         if (redirect_pc_i[1:0] != 2'b00) begin
            err_d     = 1'b1;
            discard_d = 1'b0;
            state_d   = S_ERR;
         end else begin
            case (state_q)
               S_REQ: begin
                  araddr_d  = araddr_q;
                  discard_d = 1'b1;
                  state_d   = ar_hs ? S_WAIT : S_REQ;
               end
               S_WAIT: begin
                  if (bus.mem_rvalid) begin
                     discard_d = 1'b0;
                     araddr_d  = redirect_pc_i;
                     state_d   = S_REQ;
                  end else begin
                     discard_d = 1'b1;
                     state_d   = S_WAIT;
                  end
               end
               S_HOLD: begin
                  araddr_d = redirect_pc_i;
                  state_d  = S_REQ;
               end
               default: begin
                  err_d    = 1'b0;
                  araddr_d = redirect_pc_i;
                  state_d  = S_REQ;
               end
            endcase
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= S_REQ;
         pc_q         <= RESET_PC;
         araddr_q     <= RESET_PC;
         inst_q       <= 32'd0;
         inst_pc_q    <= 32'd0;
         inst_valid_q <= 1'b0;
         discard_q    <= 1'b0;
         err_q        <= 1'b0;
      end else begin
         state_q      <= state_d;
         pc_q         <= pc_d;
         araddr_q     <= araddr_d;
         inst_q       <= inst_d;
         inst_pc_q    <= inst_pc_d;
         inst_valid_q <= inst_valid_d;
         discard_q    <= discard_d;
         err_q        <= err_d;
      end
   end

   assign bus.mem_arvalid = (state_q == S_REQ) && !rst;
   assign bus.mem_rready  = ((state_q == S_WAIT) || (state_q == S_ERR)) && !rst;
   assign bus.mem_araddr  = araddr_q;
   assign bus.inst_valid  = inst_valid_q;
   assign bus.inst        = inst_q;
   assign bus.inst_pc     = inst_pc_q;
   assign pc_o            = pc_q;
   assign fetch_err_o     = err_q;

endmodule

// File: tb/tb_ysyx_24080014_fetch_ctrl.sv
// Directed scenarios then randomized memory/decode/redirect traffic against a PC-level reference.
module tb_ysyx_24080014_fetch_ctrl;
   localparam logic [31:0] RST_PC = 32'h8000_0000;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic [31:0] pc;
   logic        fetch_err;

   always #5 clk = ~clk;

   ysyx_24080014_fetch_ctrl_if bus ();

   ysyx_24080014_fetch_ctrl #(.RESET_PC(RST_PC), .TIMEOUT_CYCLES(8)) dut (
      .clk              (clk),
      .rst              (rst),
      .bus              (bus),
      .redirect_valid_i (redirect_valid),
      .redirect_pc_i    (redirect_pc),
      .pc_o             (pc),
      .fetch_err_o      (fetch_err)
   );

   int vectors = 0;
   int miscompares = 0;

   // Reference: architectural PC and error flag, memory image, one-deep slave.
   logic [31:0] m_pc = RST_PC;
   logic        m_err = 1'b0;
   logic        chk_err = 1'b1;
   logic        rnd = 1'b0;
   logic        arready_v = 1'b0, inst_ready_v = 1'b0, redir_req = 1'b0;
   logic [31:0] redir_tgt = 32'd0;
   logic [1:0]  resp_v = 2'b00;
   int          rdelay_v = 0;
   logic        s_out = 1'b0;
   logic [31:0] s_addr = 32'd0;
   int          s_cnt = 0;
   logic        smp_arvalid, smp_rready, smp_inst_valid;
   logic [31:0] smp_araddr;
   logic        prev_pend = 1'b0;
   logic [31:0] prev_araddr = 32'd0;
   int          accepted = 0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] memfn(input logic [31:0] a);
      return a ^ 32'h8000_0013;
   endfunction

   function automatic logic [31:0] pick_target();
      logic [31:0] t;
      t = 32'h8000_0000 | (32'($urandom_range(0, 255)) << 2);
      if ($urandom_range(0, 15) == 0) t = 32'hFFFF_FFF8 | (32'($urandom_range(0, 1)) << 2);
      if ($urandom_range(0, 7) == 0)  t = t | 32'($urandom_range(1, 3));
      return t;
   endfunction

   task automatic step();
      logic hs_ar, hs_r, acc;
      if (rnd) begin
         bus.mem_arready = !s_out && ($urandom_range(0, 1) == 1);
         bus.inst_ready  = ($urandom_range(0, 1) == 1);
         redirect_valid  = 1'b0;
         if (!rst && !((m_err || fetch_err) && s_out) &&
             ($urandom_range(0, (m_err || fetch_err) ? 2 : 15) == 0)) begin
            redirect_valid = 1'b1;
            redirect_pc    = pick_target();
         end
      end else begin
         bus.mem_arready = arready_v && !s_out;
         bus.inst_ready  = inst_ready_v;
         redirect_valid  = redir_req;
         redirect_pc     = redir_tgt;
         redir_req       = 1'b0;
      end
      bus.mem_rvalid = s_out && (s_cnt == 0);
      bus.mem_rdata  = bus.mem_rvalid ? memfn(s_addr) : 32'd0;
      bus.mem_rresp  = bus.mem_rvalid ? resp_v : 2'b00;
      #1;
      smp_arvalid    = bus.mem_arvalid;
      smp_araddr     = bus.mem_araddr;
      smp_rready     = bus.mem_rready;
      smp_inst_valid = bus.inst_valid;
      @(posedge clk);
      hs_ar = smp_arvalid && bus.mem_arready;
      hs_r  = bus.mem_rvalid && smp_rready;
      acc   = smp_inst_valid && bus.inst_ready;
      prev_pend   = smp_arvalid && !bus.mem_arready;
      prev_araddr = smp_araddr;
      if (rst) begin
         m_pc = RST_PC; m_err = 1'b0; s_out = 1'b0; prev_pend = 1'b0;
      end else begin
         if (redirect_valid) begin
            m_pc  = redirect_pc;
            m_err = (redirect_pc[1:0] != 2'b00);
         end else if (acc) begin
            m_pc = m_pc + 32'd4;
         end
         if (acc) accepted++;
         if (s_out) begin
            if (hs_r) s_out = 1'b0;
            else if (s_cnt > 0) s_cnt--;
         end else if (hs_ar) begin
            s_out  = 1'b1;
            s_addr = smp_araddr;
            s_cnt  = rnd ? int'($urandom_range(0, 3)) : rdelay_v;
         end
      end
      @(negedge clk);
      check_eq("pc", pc, m_pc);
      if (chk_err) check_eq("fetch_err", 32'(fetch_err), 32'(m_err));
      if (bus.inst_valid) begin
         check_eq("inst_pc", bus.inst_pc, m_pc);
         check_eq("inst", bus.inst, memfn(bus.inst_pc));
      end
      if (fetch_err) check_eq("err_quiet", {30'd0, bus.mem_arvalid, bus.inst_valid}, 32'd0);
      if (prev_pend && bus.mem_arvalid) check_eq("araddr_stable", bus.mem_araddr, prev_araddr);
   endtask

   task automatic redirect_to(input logic [31:0] t);
      redir_req = 1'b1;
      redir_tgt = t;
      step();
   endtask

   initial begin
      redirect_valid = 1'b0; redirect_pc = 32'd0;
      bus.mem_arready = 1'b0; bus.mem_rvalid = 1'b0; bus.mem_rdata = 32'd0;
      bus.mem_rresp = 2'b00; bus.inst_ready = 1'b0;
      smp_arvalid = 1'b0; smp_rready = 1'b0; smp_inst_valid = 1'b0; smp_araddr = 32'd0;
      @(negedge clk);

      // Reset and first fetch
      step(); step();
      check_eq("rst_arvalid", 32'(bus.mem_arvalid), 32'd0);
      check_eq("rst_rready", 32'(bus.mem_rready), 32'd0);
      check_eq("rst_inst_valid", 32'(bus.inst_valid), 32'd0);
      check_eq("rst_araddr", bus.mem_araddr, RST_PC);
      check_eq("rst_inst", bus.inst, 32'd0);
      check_eq("rst_inst_pc", bus.inst_pc, 32'd0);
      rst = 1'b0; arready_v = 1'b1; rdelay_v = 0; inst_ready_v = 1'b1;
      #1;
      check_eq("t1_arvalid", 32'(bus.mem_arvalid), 32'd1);
      check_eq("t1_araddr", bus.mem_araddr, RST_PC);
      step();
      check_eq("t1_wait_rready", 32'(bus.mem_rready), 32'd1);
      step();
      check_eq("t1_inst_valid", 32'(bus.inst_valid), 32'd1);
      check_eq("t1_inst", bus.inst, 32'h0000_0013);
      check_eq("t1_inst_pc", bus.inst_pc, 32'h8000_0000);
      step();
      check_eq("t1_next_araddr", bus.mem_araddr, 32'h8000_0004);

      // Redirect in HOLD with simultaneous inst_ready
      step(); step();
      check_eq("t2_hold", 32'(bus.inst_valid), 32'd1);
      redirect_to(32'h8000_1000);
      check_eq("t2_inst_valid", 32'(bus.inst_valid), 32'd0);
      check_eq("t2_araddr", bus.mem_araddr, 32'h8000_1000);

      // Redirect during WAIT, stale response dropped
      rdelay_v = 2;
      step();
      redirect_to(32'h8000_2000);
      step(); step();
      check_eq("t3_dropped", 32'(bus.inst_valid), 32'd0);
      check_eq("t3_araddr", bus.mem_araddr, 32'h8000_2000);
      rdelay_v = 0;
      step(); step();
      check_eq("t3_inst_pc", bus.inst_pc, 32'h8000_2000);
      check_eq("t3_inst", bus.inst, 32'h0000_2013);
      step();

      // Bus error response then recovery
      chk_err = 1'b0; resp_v = 2'b10;
      step(); step();
      check_eq("t4_err", 32'(fetch_err), 32'd1);
      resp_v = 2'b00;
      for (int i = 0; i < 3; i++) begin
         step();
         check_eq("t4_no_req", 32'(bus.mem_arvalid), 32'd0);
      end
      redirect_to(32'h8000_0000);
      check_eq("t4_err_clr", 32'(fetch_err), 32'd0);
      check_eq("t4_araddr", bus.mem_araddr, 32'h8000_0000);
      chk_err = 1'b1;

      // PC wrap and misaligned redirect
      redirect_to(32'hFFFF_FFFC);
      step();
      check_eq("t5_araddr", bus.mem_araddr, 32'hFFFF_FFFC);
      step(); step();
      check_eq("t5_inst_pc", bus.inst_pc, 32'hFFFF_FFFC);
      step();
      check_eq("t5_wrap", bus.mem_araddr, 32'h0000_0000);
      arready_v = 1'b0;
      redirect_to(32'h8000_0002);
      check_eq("t5_misalign_err", 32'(fetch_err), 32'd1);
      step();
      check_eq("t5_no_req", 32'(bus.mem_arvalid), 32'd0);
      redirect_to(32'h8000_0000);

`ifdef FETCH_TIMEOUT_EN
      chk_err = 1'b0;
      for (int i = 0; i < 7; i++) begin
         step();
         check_eq("t6_not_yet", 32'(fetch_err), 32'd0);
      end
      step();
      check_eq("t6_timeout", 32'(fetch_err), 32'd1);
      redirect_to(32'h8000_0000);
`endif

      // Randomized traffic with a mid-run reset
      rnd = 1'b1; resp_v = 2'b00; chk_err = 1'b1;
`ifdef FETCH_TIMEOUT_EN
      chk_err = 1'b0;
`endif
      accepted = 0;
      for (int i = 0; i < 3000; i++) begin
         rst = (i == 1500) || (i == 1501);
         step();
      end
      check_eq("progress", 32'(accepted > 100), 32'd1);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
